// File: rtl/data_mem_ctrl_if.sv
// Load/store request bus between the core's LSU (master) and the data memory (slave).
interface data_mem_ctrl_if;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;

    modport master (
        output req, we, funct3, addr, wdata,
        input  rdata, ready, err, busy
    );

    modport slave (
        input  req, we, funct3, addr, wdata,
        output rdata, ready, err, busy
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// RV32I data memory: decodes funct3 lanes/extension, rejects illegal or misaligned requests.
// Latency LATENCY+1 cycles (errors: 1 cycle); requests are ignored while busy, no queueing.
module data_mem_ctrl #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic           clk,
    input  logic           rst,
    data_mem_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_ERR} state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_we;
    logic [2:0]      r_f3;
    logic [AW+1:0]   r_addr;
    logic [31:0]     r_wdata;
    logic [3:0]      r_cnt;
    logic [31:0]     r_rdata;
    logic [31:0]     r_mem [DEPTH];

    logic            w_idle;
    logic            w_accept;
    logic            w_c_we;
    logic [2:0]      w_c_f3;
    logic [AW+1:0]   w_c_addr;
    logic [31:0]     w_c_wdata;
    logic            w_illegal;
    logic            w_misaligned;
    logic            w_reject;
    logic            w_exec;
    logic [AW-1:0]   w_idx;
    logic [31:0]     w_word;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_load;
    logic [3:0]      w_be;
    logic [31:0]     w_wlane;
    logic            w_unused_addr;

    assign w_unused_addr = ^bus.addr[31:AW+2];

    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = w_idle && bus.req;

    // With LATENCY=0 the access executes on the accepting edge, so decode from the live bus.
    assign w_c_we    = w_idle ? bus.we             : r_we;
    assign w_c_f3    = w_idle ? bus.funct3         : r_f3;
    assign w_c_addr  = w_idle ? bus.addr[AW+1:0]   : r_addr;
    assign w_c_wdata = w_idle ? bus.wdata          : r_wdata;

    always_comb begin
        w_illegal = 1'b0;
        if (w_c_we)
            w_illegal = w_c_f3[2] || (w_c_f3 == 3'b011);
        else
            w_illegal = (w_c_f3 == 3'b011) || (w_c_f3 == 3'b110) || (w_c_f3 == 3'b111);
    end

    assign w_misaligned = ((w_c_f3[1:0] == 2'b01) && w_c_addr[0]) ||
                          ((w_c_f3[1:0] == 2'b10) && (w_c_addr[1:0] != 2'b00));
    assign w_reject     = w_illegal || w_misaligned;

    // Reset gating keeps an aborted request from touching the array while rst is held.
    assign w_exec = !rst && ((w_accept && !w_reject && (LATENCY == 0)) ||
                             ((r_state == S_WAIT) && (r_cnt == 4'd1)));

    assign w_idx  = w_c_addr[AW+1:2];
    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[{w_c_addr[1:0], 3'b000} +: 8];
    assign w_half = w_c_addr[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_load = w_word;
        case (w_c_f3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'd0, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = w_word;
        endcase
    end

    always_comb begin
        w_be    = 4'b1111;
        w_wlane = w_c_wdata;
        case (w_c_f3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << w_c_addr[1:0];
                w_wlane = {4{w_c_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = w_c_addr[1] ? 4'b1100 : 4'b0011;
                w_wlane = {2{w_c_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wlane = w_c_wdata;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.req) begin
                    if (w_reject)
                        w_next = S_ERR;
                    else if (LATENCY == 0)
                        w_next = S_RESP;
                    else
                        w_next = S_WAIT;
                end
            end
            S_WAIT:  if (r_cnt == 4'd1) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_f3    <= 3'd0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
            r_cnt   <= 4'd0;
            r_rdata <= 32'd0;
        end else begin
            if (w_accept) begin
                r_we    <= bus.we;
                r_f3    <= bus.funct3;
                r_addr  <= bus.addr[AW+1:0];
                r_wdata <= bus.wdata;
                r_cnt   <= 4'(LATENCY);
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_exec)
                r_rdata <= w_c_we ? 32'd0 : w_load;
            else if (w_accept && w_reject)
                r_rdata <= 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_exec && w_c_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b])
                    r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
            end
        end
    end

    assign bus.rdata = r_rdata;
    assign bus.ready = (r_state == S_RESP) || (r_state == S_ERR);
    assign bus.err   = (r_state == S_ERR);
    assign bus.busy  = (r_state != S_IDLE);
endmodule
